// File: rtl/lsu_datapath.sv
// Load/store unit datapath: formats core byte/half/word accesses onto a word-wide memory port.
// Runs a three-state request handshake with a bounded wait for mem_ack.
module lsu_datapath #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] load_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       wstrb_q;
  logic             err_q;
  logic [WIDTH-1:0] load_data_q;
  logic [7:0]       tmo_cnt_q;

  logic             legal, aligned;
  logic [WIDTH-1:0] wdata_fmt;
  logic [3:0]       wstrb_fmt;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [WIDTH-1:0] load_fmt;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (funct3)
      3'b000: begin legal = 1'b1;      aligned = 1'b1;                end
      3'b001: begin legal = 1'b1;      aligned = ~addr[0];            end
      3'b010: begin legal = 1'b1;      aligned = (addr[1:0] == 2'b00); end
      3'b100: begin legal = ~is_store; aligned = 1'b1;                end
      3'b101: begin legal = ~is_store; aligned = ~addr[0];            end
      default: ;
    endcase
  end

  // Stores are formatted at capture so the bus stays stable while waiting for ack.
  always_comb begin
    wdata_fmt = store_data;
    wstrb_fmt = 4'b0000;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_fmt = {4{store_data[7:0]}};
          wstrb_fmt = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          wdata_fmt = {2{store_data[15:0]}};
          wstrb_fmt = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: wstrb_fmt = 4'b1111;
      endcase
    end
  end

  always_comb begin
    rbyte    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rhalf    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_fmt = mem_rdata;
    case (funct3_q)
      3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_fmt = {24'h0, rbyte};
      3'b101:  load_fmt = {16'h0, rhalf};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (legal && aligned) ? StReq : StDone;
      StReq:   if (mem_ack || (tmo_cnt_q == TmoLast)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      err_q       <= 1'b0;
      load_data_q <= '0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_q     <= addr;
            wdata_q    <= wdata_fmt;
            wstrb_q    <= wstrb_fmt;
            err_q      <= ~(legal & aligned);
            tmo_cnt_q  <= 8'd0;
          end
        end
        StReq: begin
          if (mem_ack) begin
            err_q <= 1'b0;
            if (!is_store_q) load_data_q <= load_fmt;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (tmo_cnt_q == TmoLast) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = done & err_q;
  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req & is_store_q;
  assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;
  assign mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_datapath.sv
// Randomized self-checking bench for lsu_datapath against a transaction-level reference model.
module tb_lsu_datapath;

  localparam int Tmo = 4;

  logic        clk = 1'b0;
  logic        reset, start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_ld = '0;

  lsu_datapath #(.WIDTH(32), .TIMEOUT(Tmo)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_model(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    bit ok;
    ok   = (f3 inside {3'd0, 3'd1, 3'd2}) || (!st && (f3 inside {3'd4, 3'd5}));
    size = 1 << f3[1:0];
    return ok && ((a % size) == 0);
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int unsigned ofs;
    logic [31:0] b, h;
    ofs = a[1:0];
    b = (rd >> (8 * ofs)) & 32'hFF;
    h = (rd >> (16 * (ofs / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic store_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                             output logic [31:0] wd, output logic [3:0] strb);
    int unsigned ofs;
    ofs = a[1:0];
    case (f3[1:0])
      2'd0:    begin wd = (sd & 32'hFF) * 32'h0101_0101; strb = 4'(1 << ofs); end
      2'd1:    begin wd = (sd & 32'hFFFF) * 32'h0001_0001; strb = (ofs >= 2) ? 4'hC : 4'h3; end
      default: begin wd = sd; strb = 4'hF; end
    endcase
  endtask

  // ack_at: REQ-relative cycle on which mem_ack is driven (0 = never).
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                         input bit poke);
    bit ok, exp_err;
    int dcyc;
    logic [31:0] exp_wd, new_ld;
    logic [3:0] exp_strb;
    ok = legal_model(st, f3, a);
    if (!ok) begin dcyc = 1; exp_err = 1; end
    else if (ack_at >= 1 && ack_at <= Tmo) begin dcyc = ack_at + 1; exp_err = 0; end
    else begin dcyc = Tmo + 1; exp_err = 1; end
    store_model(f3, a, sd, exp_wd, exp_strb);
    new_ld = (ok && !st && !exp_err) ? load_model(f3, a, rd) : model_ld;

    @(negedge clk);
    start = 1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd;
    mem_ack = 0;
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      start = 0;
      if (c < dcyc) begin
        check("req_mem_req", mem_req, 1);
        check("req_busy", busy, 1);
        check("req_done", done, 0);
        check("req_mem_addr", mem_addr, {a[31:2], 2'b00});
        check("req_mem_we", mem_we, st);
        check("req_wstrb", mem_wstrb, st ? exp_strb : 4'h0);
        if (st) check("req_wdata", mem_wdata, exp_wd);
        if (poke) begin start = 1; addr = a ^ 32'h0000_0140; funct3 = 3'd2; end
      end else begin
        model_ld = new_ld;
        check("done_pulse", done, 1);
        check("done_err", err, exp_err);
        check("done_mem_req", mem_req, 0);
        check("done_wstrb", mem_wstrb, 0);
        check("done_load_data", load_data, model_ld);
      end
      mem_ack = (c == ack_at);
    end
    @(negedge clk);
    mem_ack = 0;
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_err", err, 0);
    check("post_load_data", load_data, model_ld);
  endtask

  initial begin
    reset = 0; start = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_rdata = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_load_data", load_data, 0);
    reset = 1;

    run_txn(0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 0);   // LB sign-extend
    check("lb_value", load_data, 32'hFFFF_FF80);
    run_txn(1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 3, 0);   // SH upper half
    run_txn(0, 3'd2, 32'h0000_0001, 32'h0, 32'h1234_5678, 1, 0);   // misaligned LW
    check("misaligned_ld_kept", load_data, 32'hFFFF_FF80);
    run_txn(0, 3'd5, 32'h0000_0030, 32'h0, 32'hAAAA_5555, 0, 0);   // LHU timeout
    run_txn(1, 3'd4, 32'h0000_0040, 32'h0, 32'h0, 1, 0);           // SBU illegal
    run_txn(0, 3'd2, 32'h0000_3008, 32'h0, 32'hCAFE_F00D, 3, 1);   // start while busy
    run_txn(0, 3'd5, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 2, 0);   // LHU upper
    check("lhu_value", load_data, 32'h0000_8001);

    // Reset mid-access.
    @(negedge clk);
    start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h0000_5000; mem_ack = 0;
    @(negedge clk);
    start = 0;
    check("midrst_req", mem_req, 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_done", done, 0);
    check("midrst_load_data", load_data, 0);
    model_ld = '0;
    reset = 1;
    @(negedge clk);
    check("midrst_no_done", done, 0);
    check("midrst_idle", busy, 0);

    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, $urandom_range(0, 6), $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_datapath.md
LSU_DATAPATH -- requirements
Module: lsu_datapath

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data and address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of REQ-state cycles waited for mem_ack (range 1..255).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-low.
REQ-005 start  input  1  core request, sampled only in IDLE.
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  WIDTH  byte address, taken from the ALU result.
REQ-009 store_data  input  WIDTH  rs2 value.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done: misaligned, illegal funct3, or timeout.
REQ-013 load_data  output  WIDTH  formatted load result.
REQ-014 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-015 mem_addr  output  WIDTH  word address {addr[31:2], 2'b00}.
REQ-016 mem_wdata  output  WIDTH; mem_wstrb  output  4  store data and byte strobes.
REQ-017 mem_rdata  input  WIDTH; mem_ack  input  1  memory read data and acknowledge.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-019 In IDLE with start=1, the block SHALL capture is_store, funct3, addr and store_data.
- Legal and aligned request: next state SHALL be REQ.
- Otherwise: next state SHALL be DONE with the error flag set.
REQ-020 Alignment rules:
- H/HU SHALL require addr[0]=0.
- W SHALL require addr[1:0]=00.
- funct3 values 011, 110, 111, and stores with funct3 100 or 101, SHALL be illegal.
REQ-021 In REQ:
- mem_req SHALL be 1.
- mem_addr, mem_we, mem_wdata and mem_wstrb SHALL be held stable until mem_ack is sampled high.
- On mem_ack, next state SHALL be DONE.
REQ-022 Store formatting:
- SB: byte replicated to all 4 lanes; mem_wstrb = 4'b0001 << addr[1:0].
- SH: halfword replicated to both halves; mem_wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
- SW: data unchanged; mem_wstrb = 1111.
- For loads, mem_wstrb SHALL be 0000.
REQ-023 Load formatting on ack:
- Select the byte lane addr[1:0] or the half lane addr[1].
- B/H: sign-extend; BU/HU: zero-extend; W: pass through.
- The result SHALL be registered into load_data.
REQ-024 load_data SHALL hold its value until the next successful load; stores and errors SHALL NOT change it.
REQ-025 A timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
- On reaching TIMEOUT without ack: next state SHALL be DONE with err=1 and mem_req dropped.
- load_data SHALL be unchanged.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE; err SHALL be 0 whenever done=0.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 Latency SHALL be as follows:
- start at cycle 0 and ack at cycle k (k>=1): done at cycle k+1.
- Error detected in IDLE: done at cycle 1.
REQ-029 mem_ack outside REQ SHALL be ignored.
REQ-030 mem_req, mem_we and mem_wstrb SHALL be 0 outside REQ.

Reset
REQ-031 With reset=0 at a rising edge, next state SHALL be IDLE, and the following SHALL all be 0: busy, done, err, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, load_data, timeout counter.
REQ-032 Reset asserted in REQ SHALL abort the access: mem_req=0 next cycle, and no done pulse is produced.

Verification
REQ-033 LB sign-extension:
- Stimulus: LB, addr=0x1003, mem_rdata=0x80FF_1234, ack on the 1st REQ cycle.
- Required: mem_addr=0x1000; done at cycle 2; load_data=0xFFFF_FF80; err=0.
REQ-034 SH upper half:
- Stimulus: SH, addr=0x2002, store_data=0x0000_BEEF, ack after 3 cycles.
- Required: mem_wdata=0xBEEF_BEEF and mem_wstrb=1100, held stable for 3 cycles; done at cycle 4.
REQ-035 Misaligned LW:
- Stimulus: LW, addr=0x0001.
- Required: mem_req never asserts; done=1 and err=1 at cycle 1; load_data unchanged.
REQ-036 Timeout:
- Stimulus: LHU with TIMEOUT=4, ack never arrives.
- Required: mem_req high for 4 cycles, then done=1 and err=1.
REQ-037 Start while busy:
- Stimulus: start pulsed during REQ with different addr.
- Required: ignored; captured address unchanged.
REQ-038 Reset mid-access:
- Stimulus: reset=0 during REQ.
- Required: next cycle busy=0, mem_req=0, load_data=0, no done pulse.
